// File: rtl/sched_pend_table.sv
// Per-flow rt/ack/data pending table fed by scheduler commands, with a round-robin
// scanner that hands one grant at a time (flowid + pending bits) to the TX work engine.
package sched_pkg;
  localparam int MAX_FLOW_CNT = 16;
  localparam int FLOWID_W     = 8;
  localparam int TS_W         = 16;

  typedef enum logic [1:0] {
    SC_NOP   = 2'd0,
    SC_SET   = 2'd1,
    SC_CLEAR = 2'd2
  } sc_cmd_e;

  typedef struct packed {
    sc_cmd_e           cmd;
    logic [TS_W-1:0]   timestamp;
  } pend_set_clear_t;

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    pend_set_clear_t     rt_pend_set_clear;
    pend_set_clear_t     ack_pend_set_clear;
    pend_set_clear_t     data_pend_set_clear;
  } sched_cmd_struct;
endpackage

module sched_pend_table
  import sched_pkg::*;
#(
  parameter int NUM_FLOWS = MAX_FLOW_CNT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                src_sched_cmd_val,
  input  sched_cmd_struct     src_sched_cmd,
  output logic                sched_cmd_src_rdy,
  output logic                sched_dst_val,
  output logic [FLOWID_W-1:0] sched_dst_flowid,
  output logic [2:0]          sched_dst_pend,
  input  logic                dst_sched_rdy
);

  localparam int PTR_W = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;

  typedef enum logic {ST_SCAN, ST_OUT} state_e;

  state_e                     state_q, state_d;
  logic [PTR_W-1:0]           scan_ptr_q, scan_ptr_d;
  logic [NUM_FLOWS-1:0][2:0]  table_q, table_d;
  logic                       val_q, val_d;
  logic [FLOWID_W-1:0]        flowid_q, flowid_d;
  logic [2:0]                 pend_q, pend_d;

  logic                       cmd_hit;
  logic [PTR_W-1:0]           cmd_idx;
  logic [PTR_W-1:0]           ptr_next;
  logic [2:0]                 cur_entry;
  logic                       unused_ts;

  function automatic logic apply_sc(input logic cur, input sc_cmd_e c);
    case (c)
      SC_SET:   apply_sc = 1'b1;
      SC_CLEAR: apply_sc = 1'b0;
      default:  apply_sc = cur;
    endcase
  endfunction

  assign sched_cmd_src_rdy = 1'b1;
  assign sched_dst_val     = val_q;
  assign sched_dst_flowid  = flowid_q;
  assign sched_dst_pend    = pend_q;

  assign unused_ts = ^{src_sched_cmd.rt_pend_set_clear.timestamp,
                       src_sched_cmd.ack_pend_set_clear.timestamp,
                       src_sched_cmd.data_pend_set_clear.timestamp};

  assign cmd_hit   = src_sched_cmd_val && (int'(src_sched_cmd.flowid) < NUM_FLOWS);
  assign cmd_idx   = src_sched_cmd.flowid[PTR_W-1:0];
  assign ptr_next  = (scan_ptr_q == PTR_W'(NUM_FLOWS - 1)) ? '0 : scan_ptr_q + 1'b1;
  assign cur_entry = table_q[scan_ptr_q];

  always_comb begin
    state_d    = state_q;
    scan_ptr_d = scan_ptr_q;
    table_d    = table_q;
    val_d      = val_q;
    flowid_d   = flowid_q;
    pend_d     = pend_q;

    case (state_q)
      ST_SCAN: begin
        if (|cur_entry) begin
          flowid_d = FLOWID_W'(scan_ptr_q);
          pend_d   = cur_entry;
          val_d    = 1'b1;
          state_d  = ST_OUT;
        end else begin
          scan_ptr_d = ptr_next;
        end
      end
      default: begin
        // scan_ptr does not move while in OUT, so it still indexes the granted flow
        if (dst_sched_rdy) begin
          table_d[scan_ptr_q] = table_q[scan_ptr_q] & ~pend_q;
          val_d      = 1'b0;
          scan_ptr_d = ptr_next;
          state_d    = ST_SCAN;
        end
      end
    endcase

    // Applied after the grant consume so a same-cycle SET re-arms the bit
    if (cmd_hit) begin
      table_d[cmd_idx][2] = apply_sc(table_d[cmd_idx][2], src_sched_cmd.rt_pend_set_clear.cmd);
      table_d[cmd_idx][1] = apply_sc(table_d[cmd_idx][1], src_sched_cmd.ack_pend_set_clear.cmd);
      table_d[cmd_idx][0] = apply_sc(table_d[cmd_idx][0], src_sched_cmd.data_pend_set_clear.cmd);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      scan_ptr_q <= '0;
      table_q    <= '0;
      val_q      <= 1'b0;
      flowid_q   <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      scan_ptr_q <= scan_ptr_d;
      table_q    <= table_d;
      val_q      <= val_d;
      flowid_q   <= flowid_d;
      pend_q     <= pend_d;
    end
  end

endmodule

// File: tb/tb_sched_pend_table.sv
// Scoreboard bench for sched_pend_table: stimulus pushes expected grants, a monitor
// pops and compares them at each handshake.
module tb_sched_pend_table;
  import sched_pkg::*;

  localparam int NF = MAX_FLOW_CNT;

  logic                clk = 1'b0;
  logic                rst;
  logic                src_sched_cmd_val;
  sched_cmd_struct     src_sched_cmd;
  logic                sched_cmd_src_rdy;
  logic                sched_dst_val;
  logic [FLOWID_W-1:0] sched_dst_flowid;
  logic [2:0]          sched_dst_pend;
  logic                dst_sched_rdy;

  typedef struct {
    int         fid;
    logic [2:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sched_pend_table #(.NUM_FLOWS(NF)) dut (
    .clk               (clk),
    .rst               (rst),
    .src_sched_cmd_val (src_sched_cmd_val),
    .src_sched_cmd     (src_sched_cmd),
    .sched_cmd_src_rdy (sched_cmd_src_rdy),
    .sched_dst_val     (sched_dst_val),
    .sched_dst_flowid  (sched_dst_flowid),
    .sched_dst_pend    (sched_dst_pend),
    .dst_sched_rdy     (dst_sched_rdy)
  );

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && sched_dst_val && dst_sched_rdy) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_grant: got flowid %0d pend %b, expected no grant",
                 sched_dst_flowid, sched_dst_pend);
      end else begin
        e = exp_q.pop_front();
        check("grant_flowid", int'(sched_dst_flowid), e.fid);
        check("grant_pend", int'(sched_dst_pend), int'(e.pend));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input int fid, input sc_cmd_e rt, input sc_cmd_e ack, input sc_cmd_e data);
    src_sched_cmd                          = '0;
    src_sched_cmd.flowid                   = FLOWID_W'(fid);
    src_sched_cmd.rt_pend_set_clear.cmd    = rt;
    src_sched_cmd.ack_pend_set_clear.cmd   = ack;
    src_sched_cmd.data_pend_set_clear.cmd  = data;
    src_sched_cmd.data_pend_set_clear.timestamp = 16'hBEEF;
    src_sched_cmd_val                      = 1'b1;
  endtask

  task automatic send(input int fid, input sc_cmd_e rt, input sc_cmd_e ack, input sc_cmd_e data);
    drive_cmd(fid, rt, ack, data);
    tick();
    src_sched_cmd_val = 1'b0;
  endtask

  task automatic push(input int fid, input logic [2:0] pend);
    exp_t e;
    e.fid  = fid;
    e.pend = pend;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    src_sched_cmd_val = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_val(input string name);
    int n = 0;
    while (!sched_dst_val && n < 100) begin
      tick();
      n++;
    end
    check(name, int'(sched_dst_val), 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || sched_dst_val) && n < 300) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic quiet(input string name, input int cycles);
    int c = 0;
    repeat (cycles) begin
      if (sched_dst_val) c++;
      tick();
    end
    check(name, c, 0);
  endtask

  initial begin
    rst               = 1'b1;
    src_sched_cmd_val = 1'b0;
    src_sched_cmd     = '0;
    dst_sched_rdy     = 1'b1;

    // Reset state
    do_reset();
    check("rst_val", int'(sched_dst_val), 0);
    check("rst_flowid", int'(sched_dst_flowid), 0);
    check("rst_pend", int'(sched_dst_pend), 0);
    check("rst_src_rdy", int'(sched_cmd_src_rdy), 1);

    // Single data grant on flow 3, then nothing more
    push(3, 3'b001);
    send(3, SC_NOP, SC_NOP, SC_SET);
    wait_idle("t1_drain");
    quiet("t1_quiet", 2 * NF);

    // Flow 1 lands right where the scanner looks next, flow 5 comes after
    do_reset();
    push(1, 3'b101);
    push(5, 3'b010);
    send(1, SC_SET, SC_NOP, SC_SET);
    send(5, SC_NOP, SC_SET, SC_NOP);
    wait_idle("t2_drain");
    quiet("t2_quiet", NF);

    // Backpressure: outputs held for 10 cycles
    dst_sched_rdy = 1'b0;
    push(2, 3'b001);
    send(2, SC_NOP, SC_NOP, SC_SET);
    wait_val("t3_val_seen");
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_val", int'(sched_dst_val), 1);
      check("t3_hold_flowid", int'(sched_dst_flowid), 2);
      check("t3_hold_pend", int'(sched_dst_pend), 1);
      tick();
    end
    dst_sched_rdy = 1'b1;
    wait_idle("t3_drain");
    quiet("t3_no_regrant", 2 * NF);

    // SET on the same bit in the handshake cycle re-arms the flow
    dst_sched_rdy = 1'b0;
    push(2, 3'b001);
    send(2, SC_NOP, SC_NOP, SC_SET);
    wait_val("t4_val_seen");
    push(2, 3'b001);
    dst_sched_rdy = 1'b1;
    send(2, SC_NOP, SC_NOP, SC_SET);
    wait_idle("t4_drain");
    quiet("t4_quiet", 2 * NF);

    // Freeze the scanner on flow 10, then exercise command handling elsewhere
    dst_sched_rdy = 1'b0;
    push(10, 3'b001);
    send(10, SC_NOP, SC_NOP, SC_SET);
    wait_val("t5_val_seen");
    check("t5_frozen_flowid", int'(sched_dst_flowid), 10);
    send(4, SC_NOP, SC_NOP, SC_SET);
    send(4, SC_NOP, SC_NOP, SC_CLEAR);
    send(12, SC_SET, SC_NOP, SC_NOP);
    send(12, SC_NOP, SC_NOP, SC_NOP);
    send(6, SC_NOP, SC_NOP, SC_NOP);
    send(NF, SC_SET, SC_SET, SC_SET);
    send(10, SC_NOP, SC_NOP, SC_CLEAR);
    check("t5_held_pend", int'(sched_dst_pend), 1);
    check("t5_held_val", int'(sched_dst_val), 1);
    push(12, 3'b100);
    dst_sched_rdy = 1'b1;
    wait_idle("t5_drain");
    quiet("t5_quiet", 2 * NF);

    // Reset while granting flow 0 loses the grant and the table
    do_reset();
    dst_sched_rdy = 1'b0;
    send(0, SC_NOP, SC_NOP, SC_SET);
    send(7, SC_NOP, SC_NOP, SC_SET);
    wait_val("t6_first_seen");
    check("t6_first_flowid", int'(sched_dst_flowid), 7);
    push(7, 3'b001);
    dst_sched_rdy = 1'b1;
    tick();
    dst_sched_rdy = 1'b0;
    wait_val("t6_second_seen");
    check("t6_second_flowid", int'(sched_dst_flowid), 0);
    check("t6_second_pend", int'(sched_dst_pend), 1);
    rst = 1'b1;
    tick();
    check("t6_rst_val", int'(sched_dst_val), 0);
    rst = 1'b0;
    dst_sched_rdy = 1'b1;
    quiet("t6_quiet", 2 * NF);

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
